abs_diff_sad_acc: RTL

Streaming sum-of-absolute-differences accumulator that sits directly downstream of the abs_diff_1 datapath (exact or approximate variant). It consumes one 5-bit |a-b| result per handshake and sums BLOCK_LEN results into one block SAD. It presents the SAD with a valid/ready handshake. The block lets approximate abs_diff variants be scored on block-level SAD error instead of per-sample error.

---
 rtl/abs_diff_pkg.sv | 20 ++
 rtl/abs_diff_sad_out_reg.sv | 33 +++
 rtl/abs_diff_sad_acc.sv | 80 ++++++++
 3 files changed

// File: rtl/abs_diff_pkg.sv
// Shared types and width derivations for the abs_diff block-metric stages.
package abs_diff_pkg;

    localparam int DIFF_W_DEF = 5;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Sized so that block_len samples of (2^diff_w - 1) can never overflow.
    function automatic int acc_width(input int diff_w, input int block_len);
        return diff_w + $clog2(block_len);
    endfunction

    function automatic int cnt_width(input int block_len);
        return $clog2(block_len + 1);
    endfunction

endpackage

// File: rtl/abs_diff_sad_out_reg.sv
// Output holding register with valid/ready handshake for block-metric results.
module abs_diff_sad_out_reg #(
    parameter int ACC_W = 9,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_sum,
    input  logic [CNT_W-1:0] load_count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sum   <= load_sum;
            out_count <= load_count;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/abs_diff_sad_acc.sv
// Streaming SAD accumulator: sums BLOCK_LEN |a-b| samples per block and holds the result.
module abs_diff_sad_acc
    import abs_diff_pkg::*;
#(
    parameter int DIFF_W    = DIFF_W_DEF,
    parameter int BLOCK_LEN = 16,
    parameter int ACC_W     = acc_width(DIFF_W, BLOCK_LEN),
    parameter int CNT_W     = cnt_width(BLOCK_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIFF_W-1:0] in_diff,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             close;

    assign in_ready = (state == ST_ACCUM);
    assign accept   = in_valid && in_ready;
    assign acc_next = accept ? acc + ACC_W'(in_diff) : acc;
    assign cnt_next = accept ? cnt + CNT_W'(1) : cnt;

    // A flush on an empty block is dropped so no zero-sample result is emitted.
    assign close = in_ready &&
                   ((accept && (cnt == CNT_W'(BLOCK_LEN - 1))) ||
                    (flush && ((cnt != '0) || accept)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACCUM;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (close) begin
                        state <= ST_HOLD;
                        acc   <= '0;
                        cnt   <= '0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) state <= ST_ACCUM;
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

    abs_diff_sad_out_reg #(
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (close),
        .load_sum  (acc_next),
        .load_count(cnt_next),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

endmodule
